// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer driving the PC register and a req/gnt/rvalid imem port
module fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic            pc_en,
  output logic [XLEN-1:0] npc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            id_ready,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  output logic [31:0]     fetch_cnt
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

  state_t          state, state_nx;
  logic            kill, kill_nx;
  logic            redirect, accept, capture;
  logic [XLEN-1:0] target;

  assign imem_addr = pc;

  always_comb begin
    redirect    = (trap | br_taken) && (state != BOOT);
    target      = trap ? trap_vec : br_target;
    target[1:0] = 2'b00;
    accept      = (state == HOLD) && inst_valid && id_ready;
    capture     = (state == WAIT) && imem_rvalid && !kill && !redirect;
    state_nx    = state;
    kill_nx     = kill;
    pc_en       = 1'b0;
    npc         = pc + XLEN'(4);
    imem_req    = (state == REQ);
    case (state)
      BOOT: begin
        pc_en    = 1'b1;
        npc      = RESET_PC;
        state_nx = REQ;
      end
      REQ:  if (imem_gnt) state_nx = WAIT;
      WAIT: if (imem_rvalid) begin
        kill_nx  = 1'b0;
        state_nx = kill ? REQ : HOLD;
      end
      HOLD: if (accept) begin
        pc_en    = 1'b1;
        state_nx = REQ;
      end
      default: state_nx = BOOT;
    endcase
    // A response arriving alongside the redirect is the stale one; drop it instead of waiting for another
    if (redirect) begin
      pc_en = 1'b1;
      npc   = target;
      if (((state == WAIT) && !imem_rvalid) || ((state == REQ) && imem_gnt)) begin
        kill_nx  = 1'b1;
        state_nx = WAIT;
      end else begin
        kill_nx  = 1'b0;
        state_nx = REQ;
      end
    end
    if (!rst) begin
      pc_en = 1'b0;
      npc   = RESET_PC;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= BOOT;
      kill       <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      fetch_cnt  <= '0;
    end else begin
      state <= state_nx;
      kill  <= kill_nx;
      if (accept) fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect || accept) inst_valid <= 1'b0;
      else if (capture)       inst_valid <= 1'b1;
      if (capture) begin
        inst    <= imem_rdata;
        inst_pc <= pc;
      end
    end
  end

endmodule
